// File: rtl/memory_access.sv
// MEM stage of the 16-bit pipelined core: drives the main-memory port and the MA/WB register.
// Optional store-to-load forwarding is enabled by defining MEM_ACCESS_FWD_EN.
module memory_access #(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 8,
    parameter int              REG_IDX_W = 4,
    parameter int              CTRL_W    = 4,
    parameter logic [CTRL_W-1:0] LOAD_OP  = 4'b1100,
    parameter logic [CTRL_W-1:0] STORE_OP = 4'b1110
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CTRL_W-1:0]    control_ex,
    input  logic [DATA_W-1:0]    result_ex,
    input  logic [DATA_W-1:0]    reg_data_ex,
    input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
    input  logic                 dest_reg_write_en_ex,
    input  logic [DATA_W-1:0]    data_from_main_memory,
    output logic [ADDR_W-1:0]    address_to_main_memory,
    output logic [DATA_W-1:0]    data_to_main_memory,
    output logic                 data_to_memory_write_en,
    output logic [REG_IDX_W-1:0] dest_reg_index_ma,
    output logic                 dest_reg_write_en_ma,
    output logic [DATA_W-1:0]    result_ma,
    output logic [DATA_W-1:0]    data_ma,
    output logic [CTRL_W-1:0]    control_ma
);

    logic is_load;
    logic is_store;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] load_data;

    assign is_load  = (control_ex == LOAD_OP);
    assign is_store = (control_ex == STORE_OP);

    // Upper result bits are ignored, so addresses wrap inside the 256-word memory.
    assign mem_addr = result_ex[ADDR_W-1:0];

    assign address_to_main_memory  = mem_addr;
    assign data_to_main_memory     = reg_data_ex;
    assign data_to_memory_write_en = is_store;

`ifdef MEM_ACCESS_FWD_EN
    logic [ADDR_W-1:0] st_addr_q;
    logic [DATA_W-1:0] st_data_q;
    logic              st_vld_q;
    logic              fwd_hit;

    // Remember the most recent store so a following load sees it even if memory commits late.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_addr_q <= '0;
            st_data_q <= '0;
            st_vld_q  <= 1'b0;
        end else if (is_store) begin
            st_addr_q <= mem_addr;
            st_data_q <= reg_data_ex;
            st_vld_q  <= 1'b1;
        end
    end

    assign fwd_hit   = st_vld_q && (st_addr_q == mem_addr);
    assign load_data = fwd_hit ? st_data_q : data_from_main_memory;
`else
    assign load_data = data_from_main_memory;
`endif

    logic [REG_IDX_W-1:0] idx_d,    idx_q;
    logic                 we_d,     we_q;
    logic [DATA_W-1:0]    result_d, result_q;
    logic [DATA_W-1:0]    data_d,   data_q;
    logic [CTRL_W-1:0]    ctrl_d,   ctrl_q;

    // Next MA/WB entry; stores never write back and only loads carry data.
    always_comb begin
        idx_d    = dest_reg_index_ex;
        we_d     = dest_reg_write_en_ex & ~is_store;
        result_d = result_ex;
        data_d   = is_load ? load_data : '0;
        ctrl_d   = control_ex;
    end

    // MA/WB pipeline register; reset squashes the in-flight entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            we_q     <= 1'b0;
            result_q <= '0;
            data_q   <= '0;
            ctrl_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            we_q     <= we_d;
            result_q <= result_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign dest_reg_index_ma    = idx_q;
    assign dest_reg_write_en_ma = we_q;
    assign result_ma            = result_q;
    assign data_ma              = data_q;
    assign control_ma           = ctrl_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: per-scenario tasks check combinational outputs inline,
// a posedge monitor compares the MA/WB register against a queue of expected entries.
module tb_memory_access;

    localparam logic [3:0] LD = 4'b1100;
    localparam logic [3:0] ST = 4'b1110;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  control_ex;
    logic [15:0] result_ex;
    logic [15:0] reg_data_ex;
    logic [3:0]  dest_reg_index_ex;
    logic        dest_reg_write_en_ex;
    logic [15:0] data_from_main_memory;
    logic [7:0]  address_to_main_memory;
    logic [15:0] data_to_main_memory;
    logic        data_to_memory_write_en;
    logic [3:0]  dest_reg_index_ma;
    logic        dest_reg_write_en_ma;
    logic [15:0] result_ma;
    logic [15:0] data_ma;
    logic [3:0]  control_ma;

    memory_access dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_ex             (control_ex),
        .result_ex              (result_ex),
        .reg_data_ex            (reg_data_ex),
        .dest_reg_index_ex      (dest_reg_index_ex),
        .dest_reg_write_en_ex   (dest_reg_write_en_ex),
        .data_from_main_memory  (data_from_main_memory),
        .address_to_main_memory (address_to_main_memory),
        .data_to_main_memory    (data_to_main_memory),
        .data_to_memory_write_en(data_to_memory_write_en),
        .dest_reg_index_ma      (dest_reg_index_ma),
        .dest_reg_write_en_ma   (dest_reg_write_en_ma),
        .result_ma              (result_ma),
        .data_ma                (data_ma),
        .control_ma             (control_ma)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic        we;
        logic [15:0] result;
        logic [15:0] data;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0]  m_st_addr = '0;
    logic [15:0] m_st_data = '0;
    logic        m_st_vld  = 1'b0;

    // Apply one EX-stage instruction just after negedge and queue its MA result.
    task automatic drive(input logic rst, input logic [3:0] c, input logic [15:0] r,
                         input logic [15:0] rd, input logic [3:0] idx,
                         input logic we, input logic [15:0] mem);
        exp_t e;
        @(negedge clk);
        reset                 = rst;
        control_ex            = c;
        result_ex             = r;
        reg_data_ex           = rd;
        dest_reg_index_ex     = idx;
        dest_reg_write_en_ex  = we;
        data_from_main_memory = mem;
        e = '0;
        if (!rst) begin
            e.idx    = idx;
            e.we     = we && (c != ST);
            e.result = r;
            e.ctrl   = c;
            if (c == LD) begin
                e.data = mem;
`ifdef MEM_ACCESS_FWD_EN
                if (m_st_vld && m_st_addr == r[7:0])
                    e.data = m_st_data;
`endif
            end
        end
        if (rst) begin
            m_st_vld  = 1'b0;
            m_st_addr = '0;
            m_st_data = '0;
        end else if (c == ST) begin
            m_st_vld  = 1'b1;
            m_st_addr = r[7:0];
            m_st_data = rd;
        end
        exp_q.push_back(e);
        #1;
    endtask

    // Scoreboard monitor for the registered MA/WB outputs.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (dest_reg_index_ma !== e.idx) begin
                n_fail++;
                $display("FAIL mon_idx got %h exp %h", dest_reg_index_ma, e.idx);
            end
            n_checks++;
            if (dest_reg_write_en_ma !== e.we) begin
                n_fail++;
                $display("FAIL mon_we got %b exp %b", dest_reg_write_en_ma, e.we);
            end
            n_checks++;
            if (result_ma !== e.result) begin
                n_fail++;
                $display("FAIL mon_result got %h exp %h", result_ma, e.result);
            end
            n_checks++;
            if (data_ma !== e.data) begin
                n_fail++;
                $display("FAIL mon_data got %h exp %h", data_ma, e.data);
            end
            n_checks++;
            if (control_ma !== e.ctrl) begin
                n_fail++;
                $display("FAIL mon_ctrl got %h exp %h", control_ma, e.ctrl);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ST, 16'h0033, 16'hBEEF, 4'd7, 1'b1, 16'h1234);
            n_checks++;
            if (data_to_memory_write_en !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_store_we got %b exp 1", data_to_memory_write_en);
            end
            n_checks++;
            if (address_to_main_memory !== 8'h33) begin
                n_fail++;
                $display("FAIL reset_addr got %h exp 33", address_to_main_memory);
            end
        end
    endtask

    task automatic test_load();
        drive(1'b0, LD, 16'd12, 16'd0, 4'd3, 1'b1, 16'd14);
        n_checks++;
        if (data_to_memory_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_we got %b exp 0", data_to_memory_write_en);
        end
        n_checks++;
        if (address_to_main_memory !== 8'd12) begin
            n_fail++;
            $display("FAIL load_addr got %h exp 0c", address_to_main_memory);
        end
    endtask

    task automatic test_store();
        drive(1'b0, ST, 16'd10, 16'd13, 4'd5, 1'b1, 16'h7777);
        n_checks++;
        if (address_to_main_memory !== 8'h0A) begin
            n_fail++;
            $display("FAIL store_addr got %h exp 0a", address_to_main_memory);
        end
        n_checks++;
        if (data_to_main_memory !== 16'd13) begin
            n_fail++;
            $display("FAIL store_data got %h exp 000d", data_to_main_memory);
        end
        n_checks++;
        if (data_to_memory_write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL store_we got %b exp 1", data_to_memory_write_en);
        end
    endtask

    task automatic test_back_to_back();
        logic st;
        for (int i = 0; i < 6; i++) begin
            st = i[0];
            drive(1'b0, st ? ST : LD, st ? 16'd10 : 16'd11, 16'h0100 + 16'(i),
                  4'(i), 1'b1, 16'h0A00 + 16'(i));
            n_checks++;
            if (data_to_memory_write_en !== st) begin
                n_fail++;
                $display("FAIL b2b_we[%0d] got %b exp %b", i, data_to_memory_write_en, st);
            end
        end
    endtask

    task automatic test_addr_wrap();
        drive(1'b0, LD, 16'h01FF, 16'h0, 4'd2, 1'b1, 16'h00FF);
        n_checks++;
        if (address_to_main_memory !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_ff got %h exp ff", address_to_main_memory);
        end
        drive(1'b0, LD, 16'h010C, 16'h0, 4'd2, 1'b1, 16'h010C);
        n_checks++;
        if (address_to_main_memory !== 8'h0C) begin
            n_fail++;
            $display("FAIL wrap_0c got %h exp 0c", address_to_main_memory);
        end
    endtask

    task automatic test_other_op();
        drive(1'b0, 4'b0001, 16'h4321, 16'h1111, 4'd9, 1'b1, 16'hDEAD);
        n_checks++;
        if (data_to_memory_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL other_we got %b exp 0", data_to_memory_write_en);
        end
    endtask

    task automatic test_forward();
        drive(1'b0, ST, 16'h0020, 16'h55AA, 4'd1, 1'b0, 16'h0);
        drive(1'b0, LD, 16'h0020, 16'h0, 4'd4, 1'b1, 16'h0);
        n_checks++;
        if (address_to_main_memory !== 8'h20) begin
            n_fail++;
            $display("FAIL fwd_addr got %h exp 20", address_to_main_memory);
        end
        drive(1'b0, LD, 16'h0021, 16'h0, 4'd4, 1'b1, 16'h0099);
    endtask

    task automatic test_mid_reset();
        drive(1'b0, LD, 16'h0042, 16'h0, 4'd6, 1'b1, 16'hCAFE);
        drive(1'b1, LD, 16'h0043, 16'h0, 4'd6, 1'b1, 16'hF00D);
        drive(1'b0, LD, 16'h0020, 16'h0, 4'd6, 1'b1, 16'h0001);
    endtask

    task automatic test_random();
        logic [3:0] c;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: c = LD;
                1: c = ST;
                default: c = 4'($urandom);
            endcase
            drive(1'b0, c, 16'($urandom), 16'($urandom), 4'($urandom),
                  1'($urandom), 16'($urandom));
            n_checks++;
            if (data_to_memory_write_en !== (c == ST)) begin
                n_fail++;
                $display("FAIL rnd_we[%0d] got %b", i, data_to_memory_write_en);
            end
            n_checks++;
            if (address_to_main_memory !== result_ex[7:0]
                || data_to_main_memory !== reg_data_ex) begin
                n_fail++;
                $display("FAIL rnd_port[%0d] addr %h data %h", i,
                         address_to_main_memory, data_to_main_memory);
            end
        end
    endtask

    initial begin
        reset                 = 1'b1;
        control_ex            = '0;
        result_ex             = '0;
        reg_data_ex           = '0;
        dest_reg_index_ex     = '0;
        dest_reg_write_en_ex  = 1'b0;
        data_from_main_memory = '0;
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_addr_wrap();
        test_other_op();
        test_forward();
        test_mid_reset();
        test_random();
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
